// File: rtl/adc_current_sampler.sv
// adc_current_sampler
//   Calibration sweep controller for one AD7265 dual simultaneous-sampling
//   12-bit ADC on the driver-board current-sense channels. A cal_start pulse
//   converts NCHAN channel pairs in turn, writes every A/B result into the
//   register bank over the write bus and publishes the sum of all results.
//
// Ports
//   clock        system clock, also gated out as ADC SCLK (idles high)
//   reset        synchronous active-high reset
//   soft_reset   synchronous active-high reset from the bus master
//   cal_start    one-clock pulse that starts a sweep (ignored unless idle)
//   wr_req       bus write request
//   wr_gnt       bus write grant; write completes in the granted cycle
//   wr_addr      bus write address
//   wr_data      bus write data
//   adc_sum      sum of the results of the last completed sweep
//   douta/doutb  ADC serial data, sides A and B
//   adc_sclk_en  high to pass clock to ADC SCLK
//   adc_addr     ADC channel select
//   ncs          ADC chip select, active low
//   rng          range select (fixed 0..Vref)
//   sgl          single-ended select (fixed single-ended)
module adc_current_sampler #(
  parameter int         NCHAN       = 6,
  parameter logic [9:0] RESULT_BASE = 10'h000,
  parameter int         QUIET       = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        soft_reset,
  input  logic        cal_start,
  output logic        wr_req,
  input  logic        wr_gnt,
  output logic [9:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [15:0] adc_sum,
  input  logic        douta,
  input  logic        doutb,
  output logic        adc_sclk_en,
  output logic [2:0]  adc_addr,
  output logic        ncs,
  output logic        rng,
  output logic        sgl
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_QUIET, S_CONV, S_WR_A, S_WR_B, S_NEXT
  } state_t;

  state_t      r_state;
  logic [2:0]  r_ch;
  logic [3:0]  r_cnt;
  // Only frame bits 1..15 are ever shifted in; the result window (bits
  // 3..14) sits in [12:1] when the 16th clock arrives, bit 16 is discarded.
  logic [12:0] r_sh_a;
  logic [12:0] r_sh_b;
  logic [11:0] r_res_b;
  logic [15:0] r_acc;
  logic [9:0]  w_ch_addr;

  assign rng = 1'b0;
  assign sgl = 1'b1;

  // Side A address of the current channel; side B is the next word.
  assign w_ch_addr = RESULT_BASE + {6'd0, r_ch, 1'b0};

  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_res_b     <= '0;
      r_acc       <= '0;
      ncs         <= 1'b1;
      adc_sclk_en <= 1'b0;
      adc_addr    <= '0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      adc_sum     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cal_start) r_state <= S_START;
        end

        S_START: begin
          r_acc    <= '0;
          r_ch     <= '0;
          r_cnt    <= '0;
          adc_addr <= '0;
          r_state  <= S_QUIET;
        end

        // Channel select is updated on entry to this state, so it only
        // moves while the chip select is high.
        S_QUIET: begin
          ncs         <= 1'b1;
          adc_sclk_en <= 1'b0;
          if (r_cnt == 4'(QUIET - 1)) begin
            r_cnt       <= '0;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            ncs         <= 1'b0;
            adc_sclk_en <= 1'b1;
            r_state     <= S_CONV;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        // The ADC shifts on falling SCLK; each rising edge here captures
        // one frame bit. r_cnt==15 is the 16th and last SCLK of the frame.
        S_CONV: begin
          r_sh_a <= {r_sh_a[11:0], douta};
          r_sh_b <= {r_sh_b[11:0], doutb};
          if (r_cnt == 4'd15) begin
            ncs         <= 1'b1;
            adc_sclk_en <= 1'b0;
            r_res_b     <= r_sh_b[12:1];
            wr_req      <= 1'b1;
            wr_addr     <= w_ch_addr;
            wr_data     <= {4'b0, r_sh_a[12:1]};
            r_acc       <= r_acc + {4'b0, r_sh_a[12:1]};
            r_cnt       <= '0;
            r_state     <= S_WR_A;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        // Request was raised on entry; hold address/data until granted.
        S_WR_A: begin
          if (wr_gnt) begin
            wr_req  <= 1'b0;
            r_state <= S_WR_B;
          end
        end

        // First cycle re-arms the request with the side B word; the
        // one-cycle gap keeps the two writes as distinct bus requests.
        S_WR_B: begin
          if (!wr_req) begin
            wr_req  <= 1'b1;
            wr_addr <= w_ch_addr + 10'd1;
            wr_data <= {4'b0, r_res_b};
          end else if (wr_gnt) begin
            wr_req  <= 1'b0;
            r_acc   <= r_acc + {4'b0, r_res_b};
            r_state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (r_ch != 3'(NCHAN - 1)) begin
            r_ch     <= r_ch + 3'd1;
            adc_addr <= r_ch + 3'd1;
            r_cnt    <= '0;
            r_state  <= S_QUIET;
          end else begin
            adc_sum <= r_acc;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_current_sampler.sv
// Directed bench for adc_current_sampler with a behavioural AD7265 model
// and a write-bus slave whose grant can be withheld.
module tb_adc_current_sampler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        soft_reset = 1'b0;
  logic        cal_start = 1'b0;
  logic        wr_req;
  logic        wr_gnt;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] adc_sum;
  logic        douta = 1'b0;
  logic        doutb = 1'b0;
  logic        adc_sclk_en;
  logic [2:0]  adc_addr;
  logic        ncs;
  logic        rng;
  logic        sgl;

  int checks = 0;
  int errors = 0;

  logic        gnt_ok = 1'b1;
  logic        in_abort = 1'b1;
  int          wcount = 0;
  int          frame_idx = 0;
  int          bitcnt = 0;
  int          gap = 0;
  logic [2:0]  mdl_ch = '0;
  logic [15:0] frame_a;
  logic [15:0] frame_b;
  logic        sclk;

  logic [11:0] a_val [6];
  logic [11:0] b_val [6];

  initial begin
    a_val[0] = 12'h012; a_val[1] = 12'h345; a_val[2] = 12'h678;
    a_val[3] = 12'h9ab; a_val[4] = 12'hcde; a_val[5] = 12'hf01;
    b_val[0] = 12'hfed; b_val[1] = 12'hcba; b_val[2] = 12'h987;
    b_val[3] = 12'h654; b_val[4] = 12'h321; b_val[5] = 12'h0fe;
  end

  always #5 clock = ~clock;

  assign sclk   = adc_sclk_en ? clock : 1'b1;
  assign wr_gnt = wr_req & gnt_ok;

  adc_current_sampler dut (
    .clock       (clock),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .cal_start   (cal_start),
    .wr_req      (wr_req),
    .wr_gnt      (wr_gnt),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .adc_sum     (adc_sum),
    .douta       (douta),
    .doutb       (doutb),
    .adc_sclk_en (adc_sclk_en),
    .adc_addr    (adc_addr),
    .ncs         (ncs),
    .rng         (rng),
    .sgl         (sgl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC model: channel latched at ncs fall, frame {00, data, 00}, bit k
  // driven on the k-th falling SCLK edge.
  always @(negedge ncs) begin
    mdl_ch  = adc_addr;
    frame_a = {2'b00, a_val[mdl_ch], 2'b00};
    frame_b = {2'b00, b_val[mdl_ch], 2'b00};
    bitcnt  = 0;
    if (!in_abort) begin
      chk("quiet_gap", 32'(gap >= 2), 32'd1);
      chk("adc_addr", 32'(adc_addr), 32'(frame_idx % 6));
    end
    frame_idx++;
  end

  always @(negedge sclk) begin
    if (ncs == 1'b0) begin
      bitcnt++;
      if (bitcnt <= 16) begin
        douta = frame_a[16 - bitcnt];
        doutb = frame_b[16 - bitcnt];
      end
    end
  end

  always @(posedge ncs) begin
    if (!in_abort) chk("sclk_count", 32'(bitcnt), 32'd16);
  end

  // Bus slave / write monitor: a write completes at the next rising edge.
  always @(negedge clock) begin
    if (ncs) gap++;
    else     gap = 0;
    if (wr_req === 1'b1 && wr_gnt === 1'b1) begin
      chk("wr_addr", 32'(wr_addr), 32'(wcount));
      chk("wr_data", 32'(wr_data),
          32'((wcount % 2) ? b_val[wcount / 2] : a_val[wcount / 2]));
      $display("write %0d addr=%0h data=%0h", wcount, wr_addr, wr_data);
      wcount++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_cal();
    cal_start = 1'b1;
    tick(1);
    cal_start = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wcount < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("write_count_reached", 32'(wcount), 32'(n));
  endtask

  initial begin
    // Reset
    tick(50);
    chk("rst_ncs", 32'(ncs), 32'd1);
    chk("rst_sclk_en", 32'(adc_sclk_en), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_adc_sum", 32'(adc_sum), 32'd0);
    chk("rst_rng", 32'(rng), 32'd0);
    chk("rst_sgl", 32'(sgl), 32'd1);
    chk("rst_adc_addr", 32'(adc_addr), 32'd0);
    reset = 1'b0;
    tick(2);
    in_abort = 1'b0;

    // Sweep 1: normal grants
    wcount = 0; frame_idx = 0;
    pulse_cal();
    wait_writes(12, 3000);
    tick(20);
    chk("sweep1_sum", 32'(adc_sum), 32'h5FFA);
    chk("sweep1_ncs_idle", 32'(ncs), 32'd1);

    // Sweep 2: grant withheld during first WR_A, cal_start pulsed mid-sweep
    wcount = 0; frame_idx = 0;
    gnt_ok = 1'b0;
    pulse_cal();
    for (int k = 0; k < 200 && wr_req !== 1'b1; k++) tick(1);
    chk("stall_req_seen", 32'(wr_req), 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk("stall_wr_req", 32'(wr_req), 32'd1);
      chk("stall_wr_addr", 32'(wr_addr), 32'h000);
      chk("stall_wr_data", 32'(wr_data), 32'h0012);
      tick(1);
    end
    chk("stall_no_write", 32'(wcount), 32'd0);
    gnt_ok = 1'b1;
    wait_writes(4, 1000);
    pulse_cal();
    wait_writes(12, 3000);
    tick(300);
    chk("sweep2_write_total", 32'(wcount), 32'd12);
    chk("sweep2_sum", 32'(adc_sum), 32'h5FFA);

    // Sweep 3: soft_reset during channel 3 conversion
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("reset_clears_sum", 32'(adc_sum), 32'd0);
    wcount = 0; frame_idx = 0;
    pulse_cal();
    for (int k = 0; k < 3000 && !(ncs === 1'b0 && adc_addr === 3'd3); k++) tick(1);
    chk("ch3_conv_seen", 32'(adc_addr), 32'd3);
    tick(5);
    in_abort = 1'b1;
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    chk("abort_ncs", 32'(ncs), 32'd1);
    chk("abort_sclk_en", 32'(adc_sclk_en), 32'd0);
    chk("abort_wr_req", 32'(wr_req), 32'd0);
    chk("abort_adc_addr", 32'(adc_addr), 32'd0);
    tick(300);
    chk("abort_write_total", 32'(wcount), 32'd6);
    chk("abort_sum", 32'(adc_sum), 32'd0);
    chk("abort_ncs_idle", 32'(ncs), 32'd1);
    in_abort = 1'b0;

    wcount = 0; frame_idx = 0;
    pulse_cal();
    wait_writes(12, 3000);
    tick(20);
    chk("sweep4_sum", 32'(adc_sum), 32'h5FFA);
    chk("sweep4_write_total", 32'(wcount), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_current_sampler.md
Name: adc_current_sampler

Overview:
- Controller for one AD7265 dual simultaneous-sampling 12-bit ADC that digitises the driver-board current-sense channels.
- On a calibration trigger it sweeps 6 channel pairs (A and B sides), serially reads both conversions per pair, writes each result to the register bank over the PFS write bus, and publishes the sum of all 12 samples.
- Sits between the PFS register bus and the ADC pins. A behavioural AD7265 model and the bus master complete the bench.

Parameters:
- NCHAN, 6, channel pairs per sweep; adc_addr runs 0..NCHAN-1.
- RESULT_BASE, 10'h000, register write address of channel 0 side A result.
- QUIET, 2, minimum clocks ncs stays high between conversions.

Ports:
- clock  in  1  system clock; also used as ADC SCLK when gated.
- reset  in  1  synchronous active-high reset.
- soft_reset  in  1  synchronous active-high reset from the bus master; same effect as reset.
- cal_start  in  1  one-clock pulse, CAL bit of the CONTROL register; starts a sweep.
- wr_req  out  1  bus write request.
- wr_gnt  in  1  bus write grant; the write completes in the granted cycle.
- wr_addr  out  10  bus write address.
- wr_data  out  16  bus write data.
- adc_sum  out  16  sum of the 12 results of the last completed sweep.
- douta  in  1  ADC serial data, side A.
- doutb  in  1  ADC serial data, side B.
- adc_sclk_en  out  1  high to pass clock to ADC SCLK; SCLK idles high.
- adc_addr  out  3  ADC channel select.
- ncs  out  1  ADC chip select, active low.
- rng  out  1  range select.
- sgl  out  1  single-ended/differential select.

Behaviour:
- Fixed outputs: rng=0 (0..Vref range), sgl=1 (single-ended) at all times.
- Reset and soft_reset, synchronous, highest priority, also mid-sweep:
  - state IDLE, ncs=1, adc_sclk_en=0, adc_addr=0.
  - wr_req=0, wr_addr=0, wr_data=0, adc_sum=0.
  - accumulator and channel counter cleared; any sweep in progress is abandoned with no write.
- IDLE: wait for cal_start. cal_start outside IDLE is ignored.
- START: clear the accumulator, set ch=0, go to QUIET.
- QUIET: ncs=1, sclk off for QUIET clocks, adc_addr=ch, then go to CONV.
- CONV:
  - ncs=0, adc_sclk_en=1 for exactly 16 clocks.
  - douta/doutb sampled on rising clock edges; the ADC drives data on falling SCLK.
  - Frame is 2 leading zeros, 12 data bits MSB first, 2 trailing bits. Bits 3..14 (1-based) form result_a/result_b.
  - After the 16th clock: ncs=1, adc_sclk_en=0.
- WR_A:
  - wr_req=1, wr_addr=RESULT_BASE+2*ch, wr_data={4'b0,result_a}.
  - Hold these until a cycle with wr_gnt=1, then drop wr_req the next cycle.
- WR_B: same as WR_A with address RESULT_BASE+2*ch+1 and result_b.
- Accumulation: acc += result_a + result_b; the 16-bit acc cannot overflow (max 12*4095=49140).
- Next channel:
  - ch<NCHAN-1: ch++, go to QUIET.
  - otherwise: adc_sum <= acc (held until the next sweep completes), go to IDLE.
- wr_req is never asserted outside WR_A/WR_B.
- Address and data are stable while a request is pending. Grant latency is unbounded.
- adc_addr changes only while ncs=1.

Test Plan:
- Reset held 50 clocks -> ncs=1, adc_sclk_en=0, wr_req=0, adc_sum=0, rng=0, sgl=1.
- ADC model with A={012,345,678,9ab,cde,f01}h and B={fed,cba,987,654,321,0fe}h; pulse cal_start -> 12 writes in order: addr 0..11, data 012,fed,345,cba,...,f01,0fe; final adc_sum=16'h5FFA (24570).
- Each conversion -> exactly 16 gated SCLK clocks with ncs low; at least 2 idle clocks between frames; adc_addr steps 0..5.
- wr_gnt withheld 20 clocks during a WR_A -> wr_req, wr_addr and wr_data stay constant; the sweep resumes after the grant with no lost or duplicated write.
- soft_reset pulsed during channel 3 conversion -> immediate IDLE, ncs=1, no further writes, adc_sum unchanged from 0. A new cal_start then gives a full sweep with adc_sum=16'h5FFA.
- cal_start pulsed again mid-sweep -> ignored; exactly 12 writes occur.
